// File: rtl/daq_sync_pkg.sv
// Shared types for the DAQ sync controller: run modes and channel FSM states.
package daq_sync_pkg;

   // Run mode encodings as presented on the mode input.
   typedef enum logic [1:0] {
      ModeLevel    = 2'd0,
      ModeOneshot  = 2'd1,
      ModePeriodic = 2'd2,
      ModeRsvd     = 2'd3
   } daq_mode_e;

   // Per-channel FSM states.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StGap  = 2'd2,
      StHold = 2'd3
   } daq_state_e;

   // The reserved encoding behaves exactly like LEVEL, so fold it at capture time.
   function automatic daq_mode_e fold_mode(input logic [1:0] raw);
      daq_mode_e m;
      unique case (raw)
         2'd1:    m = ModeOneshot;
         2'd2:    m = ModePeriodic;
         default: m = ModeLevel;
      endcase
      return m;
   endfunction

   // Only the counted modes give stop priority over start.
   function automatic logic is_counted(input daq_mode_e m);
      return (m == ModeOneshot) || (m == ModePeriodic);
   endfunction

endpackage

// File: rtl/daq_sync_ch.sv
// Single acquisition channel: run/gap/hold FSM with a down-counter for run and gap lengths.
module daq_sync_ch
   import daq_sync_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             nstart,
   input  logic             nstop,
   input  logic             mask,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] len_cfg,
   input  logic [CNT_W-1:0] gap_cfg,
   output logic             daq_enable,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   daq_state_e       state_q, state_d;
   daq_mode_e        mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic             en_q;
   logic             done_q, done_d;
   logic [CNT_W-1:0] len_eff;
   daq_mode_e        mode_req;

   assign len_eff  = (len_cfg == '0) ? ONE : len_cfg;
   assign mode_req = fold_mode(mode);

   // Next-state, counter and captured-configuration logic.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      if (!mask) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // A counted-mode start with stop also low is suppressed: stop wins there.
               if (!nstart && !(is_counted(mode_req) && !nstop)) begin
                  state_d = StRun;
                  mode_d  = mode_req;
                  len_d   = len_eff;
                  gap_d   = gap_cfg;
                  cnt_d   = len_eff;
               end
            end
            StRun: begin
               if (mode_q == ModeLevel) begin
                  if (nstart && !nstop) begin
                     state_d = StIdle;
                  end
               end else if (!nstop) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (cnt_q == ONE) begin
                  done_d = 1'b1;
                  if (mode_q == ModeOneshot) begin
                     state_d = StHold;
                     cnt_d   = '0;
                  end else if (gap_q == '0) begin
                     cnt_d = len_q;
                  end else begin
                     state_d = StGap;
                     cnt_d   = gap_q;
                  end
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            StGap: begin
               if (!nstop) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (cnt_q == ONE) begin
                  state_d = StRun;
                  cnt_d   = len_q;
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            StHold: begin
               // Wait for start release so a held start cannot retrigger.
               if (nstart) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= StIdle;
         mode_q  <= ModeLevel;
         cnt_q   <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         en_q    <= (state_d == StRun);
         done_q  <= done_d;
      end
   end

   assign daq_enable = en_q;
   assign busy       = (state_q != StIdle);
   assign done       = done_q;

endmodule

// File: rtl/daq_sync_ctrl.sv
// Multi-channel DAQ sync controller: NCH independent channel FSMs sharing mode and length config.
module daq_sync_ctrl
   import daq_sync_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [NCH-1:0]   nstart_daq,
   input  logic [NCH-1:0]   nstop_daq,
   input  logic [NCH-1:0]   ch_mask,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] len_cfg,
   input  logic [CNT_W-1:0] gap_cfg,
   output logic [NCH-1:0]   daq_enable,
   output logic [NCH-1:0]   busy,
   output logic [NCH-1:0]   done
);

   // One self-contained FSM per channel; no cross-channel state.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      daq_sync_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk       (clk),
         .nreset    (nreset),
         .nstart    (nstart_daq[i]),
         .nstop     (nstop_daq[i]),
         .mask      (ch_mask[i]),
         .mode      (mode),
         .len_cfg   (len_cfg),
         .gap_cfg   (gap_cfg),
         .daq_enable(daq_enable[i]),
         .busy      (busy[i]),
         .done      (done[i])
      );
   end

endmodule

// File: tb/tb_daq_sync_ctrl.sv
// Self-checking bench for daq_sync_ctrl: vector table plus hand-written corner sequences.
module tb_daq_sync_ctrl;

   localparam int NCH   = 4;
   localparam int CNT_W = 16;

   logic             clk;
   logic             nreset;
   logic [NCH-1:0]   nstart_daq;
   logic [NCH-1:0]   nstop_daq;
   logic [NCH-1:0]   ch_mask;
   logic [1:0]       mode;
   logic [CNT_W-1:0] len_cfg;
   logic [CNT_W-1:0] gap_cfg;
   logic [NCH-1:0]   daq_enable;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   done;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [NCH-1:0]   ns;
      logic [NCH-1:0]   nsp;
      logic [NCH-1:0]   msk;
      logic [1:0]       md;
      logic [CNT_W-1:0] len;
      logic [CNT_W-1:0] gap;
      logic [NCH-1:0]   e_en;
      logic [NCH-1:0]   e_busy;
      logic [NCH-1:0]   e_done;
   } vec_t;

   vec_t vq[$];

   daq_sync_ctrl #(
      .NCH  (NCH),
      .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .nstart_daq(nstart_daq),
      .nstop_daq (nstop_daq),
      .ch_mask   (ch_mask),
      .mode      (mode),
      .len_cfg   (len_cfg),
      .gap_cfg   (gap_cfg),
      .daq_enable(daq_enable),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [NCH-1:0] ns, input logic [NCH-1:0] nsp,
                       input logic [NCH-1:0] msk, input logic [1:0] md,
                       input logic [CNT_W-1:0] len, input logic [CNT_W-1:0] gap,
                       input logic [NCH-1:0] e_en, input logic [NCH-1:0] e_busy,
                       input logic [NCH-1:0] e_done);
      vec_t v;
      v.ns = ns; v.nsp = nsp; v.msk = msk; v.md = md; v.len = len; v.gap = gap;
      v.e_en = e_en; v.e_busy = e_busy; v.e_done = e_done;
      vq.push_back(v);
   endtask

   task automatic idle_inputs();
      nstart_daq = '1;
      nstop_daq  = '1;
      ch_mask    = '1;
   endtask

   initial begin
      int en_cnt;
      int dn_cnt;

      idle_inputs();
      mode    = 2'd0;
      len_cfg = 16'd5;
      gap_cfg = 16'd0;
      nreset  = 1'b0;

      // LEVEL: start pulse, hold, stop; then start-over-stop priority.
      push(4'hE, 4'hF, 4'hF, 2'd0, 16'd5, 16'd0, 4'h1, 4'h1, 4'h0);
      for (int k = 0; k < 9; k++) push(4'hF, 4'hF, 4'hF, 2'd0, 16'd5, 16'd0, 4'h1, 4'h1, 4'h0);
      push(4'hF, 4'hE, 4'hF, 2'd0, 16'd5, 16'd0, 4'h0, 4'h0, 4'h0);
      push(4'hF, 4'hF, 4'hF, 2'd0, 16'd5, 16'd0, 4'h0, 4'h0, 4'h0);
      push(4'hE, 4'hF, 4'hF, 2'd0, 16'd5, 16'd0, 4'h1, 4'h1, 4'h0);
      push(4'hE, 4'hE, 4'hF, 2'd0, 16'd5, 16'd0, 4'h1, 4'h1, 4'h0);
      push(4'hF, 4'hE, 4'hF, 2'd0, 16'd5, 16'd0, 4'h0, 4'h0, 4'h0);
      // Reserved mode acts as LEVEL: len 1 must not end the run.
      push(4'hE, 4'hF, 4'hF, 2'd3, 16'd1, 16'd0, 4'h1, 4'h1, 4'h0);
      push(4'hF, 4'hF, 4'hF, 2'd3, 16'd1, 16'd0, 4'h1, 4'h1, 4'h0);
      push(4'hF, 4'hF, 4'hF, 2'd3, 16'd1, 16'd0, 4'h1, 4'h1, 4'h0);
      push(4'hF, 4'hE, 4'hF, 2'd3, 16'd1, 16'd0, 4'h0, 4'h0, 4'h0);
      // ONESHOT len 5, start held 20 cycles.
      for (int k = 1; k <= 20; k++)
         push(4'hE, 4'hF, 4'hF, 2'd1, 16'd5, 16'd0, (k <= 5) ? 4'h1 : 4'h0, 4'h1,
              (k == 6) ? 4'h1 : 4'h0);
      push(4'hF, 4'hF, 4'hF, 2'd1, 16'd5, 16'd0, 4'h0, 4'h0, 4'h0);
      // PERIODIC len 3 gap 2, stop in the second gap.
      for (int k = 1; k <= 9; k++)
         push((k == 1) ? 4'hE : 4'hF, 4'hF, 4'hF, 2'd2, 16'd3, 16'd2,
              (k == 4 || k == 5 || k == 9) ? 4'h0 : 4'h1, 4'h1,
              (k == 4 || k == 9) ? 4'h1 : 4'h0);
      push(4'hF, 4'hE, 4'hF, 2'd2, 16'd3, 16'd2, 4'h0, 4'h0, 4'h0);
      push(4'hF, 4'hF, 4'hF, 2'd2, 16'd3, 16'd2, 4'h0, 4'h0, 4'h0);
      push(4'hF, 4'hF, 4'hF, 2'd2, 16'd3, 16'd2, 4'h0, 4'h0, 4'h0);
      // PERIODIC len 3 gap 0: enable stays high, done every 3 cycles.
      for (int k = 1; k <= 10; k++)
         push((k == 1) ? 4'hE : 4'hF, 4'hF, 4'hF, 2'd2, 16'd3, 16'd0, 4'h1, 4'h1,
              (k == 4 || k == 7 || k == 10) ? 4'h1 : 4'h0);
      push(4'hF, 4'hE, 4'hF, 2'd2, 16'd3, 16'd0, 4'h0, 4'h0, 4'h0);
      // ch1 starts, ch2 masked with start, ch3 start+stop: only ch1 runs.
      push(4'h1, 4'h7, 4'hB, 2'd1, 16'd2, 16'd0, 4'h2, 4'h2, 4'h0);
      push(4'hF, 4'hF, 4'hB, 2'd1, 16'd2, 16'd0, 4'h2, 4'h2, 4'h0);
      push(4'hF, 4'hF, 4'hB, 2'd1, 16'd2, 16'd0, 4'h0, 4'h2, 4'h2);
      push(4'hF, 4'hF, 4'hF, 2'd1, 16'd2, 16'd0, 4'h0, 4'h0, 4'h0);

      // Reset state.
      #12;
      check("rst_en", daq_enable, 4'h0);
      check("rst_busy", busy, 4'h0);
      check("rst_done", done, 4'h0);
      @(negedge clk);
      nreset = 1'b1;
      step();
      check("post_rst_idle", busy, 4'h0);

      foreach (vq[i]) begin
         nstart_daq = vq[i].ns;
         nstop_daq  = vq[i].nsp;
         ch_mask    = vq[i].msk;
         mode       = vq[i].md;
         len_cfg    = vq[i].len;
         gap_cfg    = vq[i].gap;
         step();
         check($sformatf("v%0d_en", i), daq_enable, vq[i].e_en);
         check($sformatf("v%0d_busy", i), busy, vq[i].e_busy);
         check($sformatf("v%0d_done", i), done, vq[i].e_done);
      end
      idle_inputs();
      step();

      // ONESHOT len 4, len_cfg changed to 10 mid-run.
      en_cnt = 0;
      dn_cnt = 0;
      mode = 2'd1;
      len_cfg = 16'd4;
      nstart_daq = 4'hE;
      step();
      en_cnt += int'(daq_enable[0]);
      dn_cnt += int'(done[0]);
      nstart_daq = 4'hF;
      for (int k = 2; k <= 15; k++) begin
         if (k == 3) len_cfg = 16'd10;
         step();
         en_cnt += int'(daq_enable[0]);
         dn_cnt += int'(done[0]);
      end
      check_int("cfg_hold_len", en_cnt, 4);
      check_int("cfg_hold_done", dn_cnt, 1);
      check("cfg_hold_idle", busy, 4'h0);

      // Stop during the last RUN cycle aborts without done.
      len_cfg = 16'd3;
      nstart_daq = 4'hE;
      step();
      nstart_daq = 4'hF;
      step();
      step();
      check("last_cyc_en", daq_enable, 4'h1);
      nstop_daq = 4'hE;
      step();
      check("last_stop_en", daq_enable, 4'h0);
      check("last_stop_busy", busy, 4'h0);
      check("last_stop_done", done, 4'h0);
      nstop_daq = 4'hF;
      step();
      check("last_stop_done2", done, 4'h0);

      // len_cfg 0 behaves as 1.
      len_cfg = 16'd0;
      nstart_daq = 4'hE;
      step();
      check("len0_en", daq_enable, 4'h1);
      nstart_daq = 4'hF;
      step();
      check("len0_fall", daq_enable, 4'h0);
      check("len0_done", done, 4'h1);
      step();
      check("len0_idle", busy, 4'h0);

      // Mask drop mid-PERIODIC forces IDLE with no done.
      mode = 2'd2;
      len_cfg = 16'd3;
      gap_cfg = 16'd2;
      nstart_daq = 4'hE;
      step();
      nstart_daq = 4'hF;
      step();
      ch_mask = 4'hE;
      step();
      check("mask_en", daq_enable, 4'h0);
      check("mask_busy", busy, 4'h0);
      check("mask_done", done, 4'h0);
      ch_mask = 4'hF;
      step();
      check("mask_stay_idle", busy, 4'h0);

      // Async reset mid-PERIODIC with start held low, then restart.
      nstart_daq = 4'hE;
      step();
      step();
      check("pre_rst_run", daq_enable, 4'h1);
      #1;
      nreset = 1'b0;
      #1;
      check("async_en", daq_enable, 4'h0);
      check("async_busy", busy, 4'h0);
      check("async_done", done, 4'h0);
      @(posedge clk);
      #3;
      check("rst_hold_en", daq_enable, 4'h0);
      nreset = 1'b1;
      step();
      check("restart_en", daq_enable, 4'h1);
      check("restart_busy", busy, 4'h1);
      idle_inputs();
      nstop_daq = 4'hE;
      step();
      check("final_idle", busy, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/daq_sync_ctrl.md
DAQ_SYNC_CTRL -- requirements
Module: daq_sync_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of independent acquisition channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of run-length and gap counters (2..32).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 nreset  input  1  reset, asynchronous assert, active-low.
REQ-005 nstart_daq  input  NCH  per-channel start request, active-low, level-sampled.
REQ-006 nstop_daq  input  NCH  per-channel stop request, active-low, level-sampled.
REQ-007 ch_mask  input  NCH  channel enable; 0 forces channel to IDLE.
REQ-008 mode  input  2  0=LEVEL, 1=ONESHOT, 2=PERIODIC, 3=reserved (treated as LEVEL).
REQ-009 len_cfg  input  CNT_W  run length in cycles for ONESHOT/PERIODIC.
REQ-010 gap_cfg  input  CNT_W  idle cycles between PERIODIC runs.
REQ-011 daq_enable  output  NCH  per-channel acquisition enable, registered.
REQ-012 busy  output  NCH  high when channel state is not IDLE.
REQ-013 done  output  NCH  one-cycle pulse at natural end of each ONESHOT/PERIODIC run.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, RUN, GAP, HOLD.
REQ-015 mode, len_cfg, gap_cfg SHALL be captured per channel on the IDLE->RUN transition; later changes SHALL NOT affect a run in progress.
REQ-016 IDLE->RUN when nstart_daq[i]=0 and ch_mask[i]=1; daq_enable[i] SHALL be high in the cycle after the sampling edge (1-cycle latency).
REQ-017 LEVEL: RUN holds until nstop_daq[i]=0 with nstart_daq[i]=1, then IDLE; start SHALL take priority over stop when both low; done SHALL NOT pulse.
REQ-018 ONESHOT: daq_enable[i] high exactly len_cfg cycles; at the last cycle done[i] pulses with the falling of daq_enable; next state HOLD.
REQ-019 PERIODIC: after len_cfg RUN cycles, done[i] pulses, state GAP for gap_cfg cycles with daq_enable low, then RUN again; repeats indefinitely until stop.
REQ-020 gap_cfg=0 in PERIODIC SHALL give back-to-back runs with daq_enable continuously high and done pulsing every len_cfg cycles.
REQ-021 len_cfg=0 SHALL be treated as 1.
REQ-022 HOLD: daq_enable low, busy high; exit to IDLE only once nstart_daq[i]=1 (no retrigger on a held start).
REQ-023 In ONESHOT/PERIODIC, nstop_daq[i]=0 in RUN or GAP SHALL abort to IDLE next cycle, no done pulse; stop SHALL win over start in these modes.
REQ-024 Stop asserted in the same cycle as the last RUN cycle SHALL abort (no done pulse).
REQ-025 ch_mask[i]=0 in any state SHALL force IDLE next cycle with daq_enable[i]=0, no done.
REQ-026 Counters SHALL count down from captured value; no wrap-around; len_cfg=2^CNT_W-1 SHALL be supported.
REQ-027 Channels SHALL NOT interact; simultaneous events on different channels SHALL be handled independently in the same cycle.

Reset
REQ-028 nreset=0 SHALL immediately force all channels to IDLE, counters to 0, daq_enable=0, busy=0, done=0.
REQ-029 Reset mid-run SHALL abort without done pulse; after release, a start still held low SHALL start a new run on the first edge after release.

Structure
REQ-030 Mode encodings and the FSM state enumeration SHALL reside in shared package daq_sync_pkg.
REQ-031 One sub-module daq_sync_ch (single-channel FSM plus counter) SHALL be instantiated NCH times by a generate loop.

Verification
REQ-032 LEVEL, ch0: start low 1 cycle at t0 -> daq_enable[0]=1 from t0+1; stop low at t10 -> 0 from t11; done never pulses.
REQ-033 ONESHOT, len_cfg=5, start held low 20 cycles -> daq_enable high exactly 5 cycles, done 1 pulse on the last, busy stays high until start released, no second run.
REQ-034 PERIODIC, len=3, gap=2 -> enable pattern 1,1,1,0,0 repeating, done every 5 cycles; stop mid-gap -> IDLE, no further pulse; gap=0 -> enable constant, done every 3 cycles.
REQ-035 ONESHOT len=4, change len_cfg to 10 at cycle 2 of run -> run still 4 cycles.
REQ-036 NCH=4: ch1 ONESHOT start while ch2 masked and ch3 stopped same cycle -> only ch1 runs, others idle.
REQ-037 nreset pulsed low mid-PERIODIC run -> all outputs 0 asynchronously; start held low -> run restarts first edge after release.
